// File: rtl/plab2_proc_mem_arbiter.sv
// Round-robin arbiter that shares one memory port between the instruction (in0)
// and data (in1) ports, and routes in-order responses back through a FIFO of source IDs.
module plab2_proc_mem_arbiter #(
  parameter int unsigned p_max_outstanding = 4,
  parameter int unsigned p_req_nbits       = 77,
  parameter int unsigned p_resp_nbits      = 45
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [p_req_nbits-1:0]  in0_req_msg,
  input  logic                    in0_req_val,
  output logic                    in0_req_rdy,
  input  logic                    in0_req_domain,
  output logic [p_resp_nbits-1:0] in0_resp_msg,
  output logic                    in0_resp_val,
  input  logic                    in0_resp_rdy,

  input  logic [p_req_nbits-1:0]  in1_req_msg,
  input  logic                    in1_req_val,
  output logic                    in1_req_rdy,
  input  logic                    in1_req_domain,
  output logic [p_resp_nbits-1:0] in1_resp_msg,
  output logic                    in1_resp_val,
  input  logic                    in1_resp_rdy,

  output logic [p_req_nbits-1:0]  mem_req_msg,
  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic                    mem_req_domain,
  input  logic [p_resp_nbits-1:0] mem_resp_msg,
  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,

  output logic                    err_unexp_resp
);

  localparam int unsigned AW = $clog2(p_max_outstanding);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {PRI_IN0 = 1'b0, PRI_IN1 = 1'b1} pri_t;

  pri_t                         pri, pri_next;
  logic [AW-1:0]                head, tail;
  logic [CW-1:0]                count;
  logic [p_max_outstanding-1:0] ids;

  logic can_issue, gnt0, gnt1, push, pop, nonempty, head_id;

  always_comb begin
    can_issue = (count < CW'(p_max_outstanding));
    gnt0      = in0_req_val & (~in1_req_val | (pri == PRI_IN0));
    gnt1      = in1_req_val & (~in0_req_val | (pri == PRI_IN1));

    mem_req_val    = reset & can_issue & (in0_req_val | in1_req_val);
    mem_req_msg    = gnt1 ? in1_req_msg    : in0_req_msg;
    mem_req_domain = gnt1 ? in1_req_domain : in0_req_domain;
    in0_req_rdy    = reset & can_issue & gnt0 & mem_req_rdy;
    in1_req_rdy    = reset & can_issue & gnt1 & mem_req_rdy;
    push           = mem_req_val & mem_req_rdy;

    pri_next = pri;
    if (push) pri_next = gnt1 ? PRI_IN0 : PRI_IN1;

    // Responses are steered by the oldest outstanding ID; nothing is accepted when empty.
    nonempty     = (count != '0);
    head_id      = ids[head];
    in0_resp_msg = mem_resp_msg;
    in1_resp_msg = mem_resp_msg;
    in0_resp_val = reset & nonempty & mem_resp_val & ~head_id;
    in1_resp_val = reset & nonempty & mem_resp_val &  head_id;
    mem_resp_rdy = reset & nonempty & (head_id ? in1_resp_rdy : in0_resp_rdy);
    pop          = mem_resp_val & mem_resp_rdy;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pri            <= PRI_IN0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      ids            <= '0;
      err_unexp_resp <= 1'b0;
    end else begin
      pri <= pri_next;
      if (push) begin
        ids[tail] <= gnt1;
        tail      <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (mem_resp_val && !nonempty) err_unexp_resp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_plab2_proc_mem_arbiter.sv
// Bench for plab2_proc_mem_arbiter: directed scenarios then random traffic, all
// compared against a queue-based reference model of the arbiter.
module tb_plab2_proc_mem_arbiter;

  localparam int unsigned NMAX = 4;
  localparam int unsigned RQ   = 77;
  localparam int unsigned RS   = 45;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RQ-1:0] in0_req_msg = '0, in1_req_msg = '0;
  logic          in0_req_val = 1'b0, in1_req_val = 1'b0;
  logic          in0_req_rdy, in1_req_rdy;
  logic          in0_req_domain = 1'b0, in1_req_domain = 1'b0;
  logic [RS-1:0] in0_resp_msg, in1_resp_msg;
  logic          in0_resp_val, in1_resp_val;
  logic          in0_resp_rdy = 1'b0, in1_resp_rdy = 1'b0;
  logic [RQ-1:0] mem_req_msg;
  logic          mem_req_val, mem_req_domain;
  logic          mem_req_rdy = 1'b0;
  logic [RS-1:0] mem_resp_msg = '0;
  logic          mem_resp_val = 1'b0;
  logic          mem_resp_rdy;
  logic          err_unexp_resp;

  plab2_proc_mem_arbiter #(
    .p_max_outstanding(NMAX),
    .p_req_nbits(RQ),
    .p_resp_nbits(RS)
  ) dut (
    .clk(clk), .reset(reset),
    .in0_req_msg(in0_req_msg), .in0_req_val(in0_req_val), .in0_req_rdy(in0_req_rdy),
    .in0_req_domain(in0_req_domain), .in0_resp_msg(in0_resp_msg),
    .in0_resp_val(in0_resp_val), .in0_resp_rdy(in0_resp_rdy),
    .in1_req_msg(in1_req_msg), .in1_req_val(in1_req_val), .in1_req_rdy(in1_req_rdy),
    .in1_req_domain(in1_req_domain), .in1_resp_msg(in1_resp_msg),
    .in1_resp_val(in1_resp_val), .in1_resp_rdy(in1_resp_rdy),
    .mem_req_msg(mem_req_msg), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_domain(mem_req_domain), .mem_resp_msg(mem_resp_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .err_unexp_resp(err_unexp_resp)
  );

  always #5 clk = ~clk;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  // Reference model: outstanding source IDs in issue order, favoured requester, sticky error.
  int q[$];
  int ptr   = 0;
  bit err_m = 1'b0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Inputs are set at posedge+1; outputs are checked at posedge+2, then the model advances.
  task automatic step();
    bit can, any, g, ne, h, e_mval, e_rrdy;
    #1;
    can = (q.size() < NMAX);
    any = in0_req_val || in1_req_val;
    if (in0_req_val && !in1_req_val)      g = 1'b0;
    else if (in1_req_val && !in0_req_val) g = 1'b1;
    else                                  g = (ptr == 1);
    e_mval = can && any;
    check("mem_req_val", {79'd0, mem_req_val}, {79'd0, e_mval});
    if (e_mval) begin
      check("mem_req_msg", {3'd0, mem_req_msg}, {3'd0, (g ? in1_req_msg : in0_req_msg)});
      check("mem_req_domain", {79'd0, mem_req_domain}, {79'd0, (g ? in1_req_domain : in0_req_domain)});
    end
    check("in0_req_rdy", {79'd0, in0_req_rdy}, {79'd0, (e_mval && !g && mem_req_rdy)});
    check("in1_req_rdy", {79'd0, in1_req_rdy}, {79'd0, (e_mval && g && mem_req_rdy)});

    ne     = (q.size() > 0);
    h      = ne && (q[0] == 1);
    e_rrdy = ne && (h ? in1_resp_rdy : in0_resp_rdy);
    check("in0_resp_val", {79'd0, in0_resp_val}, {79'd0, (ne && mem_resp_val && !h)});
    check("in1_resp_val", {79'd0, in1_resp_val}, {79'd0, (ne && mem_resp_val && h)});
    check("mem_resp_rdy", {79'd0, mem_resp_rdy}, {79'd0, e_rrdy});
    check("in0_resp_msg", {35'd0, in0_resp_msg}, {35'd0, mem_resp_msg});
    check("in1_resp_msg", {35'd0, in1_resp_msg}, {35'd0, mem_resp_msg});
    check("err_unexp_resp", {79'd0, err_unexp_resp}, {79'd0, err_m});

    if (ne && mem_resp_val && e_rrdy) void'(q.pop_front());
    if (!ne && mem_resp_val) err_m = 1'b1;
    if (e_mval && mem_req_rdy) begin
      q.push_back(int'(g));
      ptr = g ? 0 : 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must drop without waiting for a clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_mem_req_val", {79'd0, mem_req_val}, 80'd0);
    check("rst_in0_req_rdy", {79'd0, in0_req_rdy}, 80'd0);
    check("rst_in1_req_rdy", {79'd0, in1_req_rdy}, 80'd0);
    check("rst_in0_resp_val", {79'd0, in0_resp_val}, 80'd0);
    check("rst_in1_resp_val", {79'd0, in1_resp_val}, 80'd0);
    check("rst_mem_resp_rdy", {79'd0, mem_resp_rdy}, 80'd0);
    check("rst_err", {79'd0, err_unexp_resp}, 80'd0);
    q.delete();
    ptr   = 0;
    err_m = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic idle_inputs();
    in0_req_val  = 1'b0;
    in1_req_val  = 1'b0;
    mem_resp_val = 1'b0;
    in0_resp_rdy = 1'b1;
    in1_resp_rdy = 1'b1;
    mem_req_rdy  = 1'b1;
  endtask

  initial begin
    #2;
    idle_inputs();
    do_reset();

    // Single requester: in1 issues three reads, responses return to in1 only.
    in1_req_val    = 1'b1;
    in1_req_domain = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in1_req_msg = {3'd0, 8'd0, 32'h2000 + 32'(4 * i), 2'd0, 32'd0};
      step();
    end
    in1_req_val  = 1'b0;
    mem_resp_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_resp_msg = {3'd0, 8'd0, 2'd0, 32'hA + 32'(i)};
      step();
    end
    mem_resp_val = 1'b0;
    step();

    // Contention: grants alternate starting from in0 after reset.
    do_reset();
    in0_req_val    = 1'b1;
    in1_req_val    = 1'b1;
    in0_req_domain = 1'b0;
    in1_req_domain = 1'b1;
    in0_req_msg    = {13'($urandom()), $urandom(), $urandom()};
    in1_req_msg    = {13'($urandom()), $urandom(), $urandom()};
    step();
    mem_resp_val = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_resp_msg = {13'($urandom()), $urandom()};
      step();
    end
    idle_inputs();
    step();

    // Full: four issues with no responses, then a response and a pending request together.
    do_reset();
    in0_req_val = 1'b1;
    for (int i = 0; i < 5; i++) step();
    mem_resp_val = 1'b1;
    step();
    mem_resp_val = 1'b0;
    step();
    step();

    // Backpressure: head ID 0 stalled for three cycles, then the next response goes to in1.
    do_reset();
    in0_req_val = 1'b1;
    in1_req_val = 1'b1;
    step();
    step();
    in0_req_val  = 1'b0;
    in1_req_val  = 1'b0;
    mem_resp_val = 1'b1;
    in0_resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) step();
    in0_resp_rdy = 1'b1;
    step();
    step();
    mem_resp_val = 1'b0;
    step();

    // Unexpected response with nothing outstanding.
    do_reset();
    mem_resp_val = 1'b1;
    step();
    mem_resp_val = 1'b0;
    step();
    step();
    check("err_sticky", {79'd0, err_unexp_resp}, 80'd1);

    // Reset mid-stream with two outstanding requests.
    do_reset();
    in0_req_val = 1'b1;
    step();
    step();
    in1_req_val  = 1'b1;
    mem_resp_val = 1'b1;
    do_reset();
    mem_resp_val = 1'b0;
    step();
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in0_req_val    = ($urandom_range(0, 3) != 0);
      in1_req_val    = ($urandom_range(0, 3) != 0);
      in0_req_domain = 1'($urandom());
      in1_req_domain = 1'($urandom());
      in0_req_msg    = {13'($urandom()), $urandom(), $urandom()};
      in1_req_msg    = {13'($urandom()), $urandom(), $urandom()};
      mem_req_rdy    = ($urandom_range(0, 3) != 0);
      mem_resp_val   = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 31) == 0);
      mem_resp_msg   = {13'($urandom()), $urandom()};
      in0_resp_rdy   = ($urandom_range(0, 3) != 0);
      in1_resp_rdy   = ($urandom_range(0, 3) != 0);
      step();
      if (i == 200) do_reset();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
